// File: rtl/buf_fanout_monitor.sv
// buf_fanout_monitor
//
// Watches both fanned-out copies of one buffered net (out1/out2 of a
// two-output buf stage), brings each into the clk domain through its own
// synchronizer chain, and checks that the two copies agree.  The value
// they last agreed on is forwarded on agree_out and its rising edges are
// counted.  Short disagreements count as transient episodes.  A
// disagreement that lasts MISMATCH_LIMIT consecutive synchronized cycles
// latches a sticky fault, which only clr or rst can clear.
//
// Parameters:
//   SYNC_STAGES    flops per input synchronizer chain (2..4)
//   MISMATCH_LIMIT consecutive mismatch cycles that declare a fault (2..15)
//   CNT_W          width of edge_cnt and mismatch_cnt
//
// Ports:
//   clk          sole clock, rising edge
//   rst          asynchronous active-high reset
//   in1, in2     the two buffered copies
//   clr          synchronous clear of counters and fault
//   agree_out    last agreed value (registered)
//   edge_cnt     saturating count of agree_out rising edges
//   mismatch_cnt saturating count of transient disagreement episodes
//   fault        sticky persistent-disagreement flag
//   state        FSM state: 0 AGREE, 1 SUSPECT, 2 FAULT

module buf_fanout_monitor #(
  parameter int SYNC_STAGES    = 2,
  parameter int MISMATCH_LIMIT = 3,
  parameter int CNT_W          = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in1,
  input  logic             in2,
  input  logic             clr,
  output logic             agree_out,
  output logic [CNT_W-1:0] edge_cnt,
  output logic [CNT_W-1:0] mismatch_cnt,
  output logic             fault,
  output logic [1:0]       state
);

  typedef enum logic [1:0] {
    ST_AGREE   = 2'd0,
    ST_SUSPECT = 2'd1,
    ST_FAULT   = 2'd2
  } state_t;

  localparam logic [CNT_W-1:0] CNT_MAX  = '1;
  localparam logic [CNT_W-1:0] CNT_ONE  = 1;
  localparam logic [3:0]       RUN_ONE  = 4'd1;
  localparam logic [3:0]       RUN_LAST = 4'(MISMATCH_LIMIT - 1);

  state_t             cur_state, nxt_state;
  logic [SYNC_STAGES-1:0] sync1, sync2;
  logic               s1, s2, m;
  logic [3:0]         run, run_nxt;
  logic               agree_nxt, fault_nxt;
  logic [CNT_W-1:0]   edge_nxt, mm_nxt;

  // Two independent synchronizer chains; the copies are never combined
  // before the last stage, so each one settles on its own.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync1 <= '0;
      sync2 <= '0;
    end else begin
      sync1 <= {sync1[SYNC_STAGES-2:0], in1};
      sync2 <= {sync2[SYNC_STAGES-2:0], in2};
    end
  end

  assign s1    = sync1[SYNC_STAGES-1];
  assign s2    = sync2[SYNC_STAGES-1];
  assign m     = s1 ^ s2;
  assign state = cur_state;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cur_state    <= ST_AGREE;
      run          <= '0;
      agree_out    <= 1'b0;
      fault        <= 1'b0;
      edge_cnt     <= '0;
      mismatch_cnt <= '0;
    end else begin
      cur_state    <= nxt_state;
      run          <= run_nxt;
      agree_out    <= agree_nxt;
      fault        <= fault_nxt;
      edge_cnt     <= edge_nxt;
      mismatch_cnt <= mm_nxt;
    end
  end

  // run counts consecutive mismatch cycles of the current episode; the
  // cycle that enters SUSPECT is the first one, so the fault lands on the
  // edge that samples the MISMATCH_LIMIT-th mismatch.  clr overrides every
  // transition and increment; a mismatch still present under clr simply
  // starts a fresh episode on the next edge.
  always_comb begin
    nxt_state = cur_state;
    run_nxt   = run;
    agree_nxt = agree_out;
    fault_nxt = fault;
    edge_nxt  = edge_cnt;
    mm_nxt    = mismatch_cnt;

    if (clr) begin
      nxt_state = ST_AGREE;
      run_nxt   = '0;
      fault_nxt = 1'b0;
      edge_nxt  = '0;
      mm_nxt    = '0;
      if (!m) agree_nxt = s1;
    end else begin
      case (cur_state)
        ST_AGREE: begin
          if (m) begin
            nxt_state = ST_SUSPECT;
            run_nxt   = RUN_ONE;
          end else begin
            agree_nxt = s1;
          end
        end
        ST_SUSPECT: begin
          if (m) begin
            if (run == RUN_LAST) begin
              nxt_state = ST_FAULT;
              fault_nxt = 1'b1;
              run_nxt   = '0;
            end else begin
              run_nxt = run + RUN_ONE;
            end
          end else begin
            nxt_state = ST_AGREE;
            run_nxt   = '0;
            agree_nxt = s1;
            if (mismatch_cnt != CNT_MAX) mm_nxt = mismatch_cnt + CNT_ONE;
          end
        end
        ST_FAULT: begin
          fault_nxt = 1'b1;
        end
        default: begin
          nxt_state = ST_AGREE;
        end
      endcase

      // agree_out only moves in AGREE or when leaving SUSPECT, so this
      // cannot fire while holding in SUSPECT or FAULT.
      if (!agree_out && agree_nxt && (edge_cnt != CNT_MAX))
        edge_nxt = edge_cnt + CNT_ONE;
    end
  end

endmodule

// File: doc/buf_fanout_monitor.md
Name: buf_fanout_monitor

Overview:
- Sits directly downstream of a two-output buf gate stage; consumes both fanned-out copies (out1, out2) of one buffered net.
- Synchronizes both copies into the clk domain and checks that they agree.
- Forwards a single agreed value, counts its rising edges, classifies short disagreements as transients and long ones as a sticky fault.

Parameters:
SYNC_STAGES, 2, flops per input synchronizer chain (legal range 2..4)
MISMATCH_LIMIT, 3, consecutive synchronized mismatch cycles that declare a fault (legal range 2..15)
CNT_W, 8, width of edge_cnt and mismatch_cnt

Ports:
clk  input  1  sole clock, rising edge
rst  input  1  asynchronous active-high reset
in1  input  1  first buffered copy (from buf output out1)
in2  input  1  second buffered copy (from buf output out2)
clr  input  1  synchronous clear of counters and fault, active-high
agree_out  output  1  last value on which both copies agreed, registered
edge_cnt  output  CNT_W  rising edges of agree_out, saturating
mismatch_cnt  output  CNT_W  transient disagreement episodes, saturating
fault  output  1  sticky; persistent disagreement detected
state  output  2  FSM state: 0 AGREE, 1 SUSPECT, 2 FAULT

Behaviour:
- Reset (async, rst=1): all outputs 0, all synchronizer flops 0, run counter 0, state AGREE. Reset mid-episode discards the episode: no count, no fault.
- Synchronizers: s1 and s2 are the last flops of independent SYNC_STAGES chains on in1 and in2.
- Latency: an agreeing change on in1/in2 reaches agree_out SYNC_STAGES+1 clk edges later.
- Mismatch is defined as m = s1 ^ s2.
- AGREE state:
  - m=0: agree_out <= s1.
  - m=1: go to SUSPECT, run <= 1, agree_out holds.
- SUSPECT state (agree_out holds):
  - m=1 and run == MISMATCH_LIMIT-1: go to FAULT, fault <= 1, run <= 0.
  - m=1 otherwise: run <= run+1.
  - m=0: go to AGREE, mismatch_cnt <= mismatch_cnt+1 (saturating), run <= 0, agree_out <= s1 on that same edge.
- FAULT state:
  - fault=1; agree_out holds; counters frozen.
  - Leaves only on clr or rst.
- Fault timing: fault asserts on the edge that samples the MISMATCH_LIMIT-th consecutive m=1.
- edge_cnt: increments (saturating at 2^CNT_W-1) on every edge where agree_out goes 0->1. Never increments in SUSPECT or FAULT.
- clr=1 (synchronous, any state): edge_cnt, mismatch_cnt, fault, run <= 0; state <= AGREE.
  - agree_out <= s1 if m=0, else holds.
  - clr has priority over every same-cycle transition and increment.
  - If m=1 during clr, the run restarts on the following edge (run=1 there).
- Saturation: at 2^CNT_W-1 a counter holds; no wrap.
- Glitches on in1/in2 shorter than one clk period may be missed by the synchronizers; not required to be counted.

Test Plan:
- rst=1 then release, in1=in2=0 for 10 cycles -> all outputs 0, state=0.
- in1=in2 toggle 0->1->0->1 with 5-cycle spacing -> agree_out follows 3 cycles after each change (SYNC_STAGES=2); edge_cnt=2, mismatch_cnt=0.
- in1=1, in2=0 for 2 synchronized cycles, then in2=1 -> state 0->1->0, mismatch_cnt=1, fault=0, agree_out=1, edge_cnt=1.
- in1=1, in2=0 held 3 cycles -> fault=1 on the 3rd mismatch edge, state=2; further toggling leaves all counters and agree_out unchanged.
- In FAULT, pulse clr=1 with in1=in2=1 -> next edge fault=0, counters=0, state=0, agree_out=1.
- CNT_W=2, drive 5 agreed rising edges -> edge_cnt saturates at 3. Assert rst mid-SUSPECT -> all outputs 0 immediately, without waiting for a clock edge.
